// File: rtl/vreg_pkg.sv
// Shared constants, FSM state type and address-decode helpers for the
// masked vector register file.
package vreg_pkg;

  localparam int LANES_D    = 8;
  localparam int LANE_W_D   = 32;
  localparam int NUM_REGS_D = 16;
  localparam int VEC_BASE_D = 16;

  typedef enum logic {VR_IDLE = 1'b0, VR_CLEAR = 1'b1} vr_state_t;

  // True when addr falls inside the architectural window of the vector file.
  function automatic logic addr_valid(input logic [31:0] addr,
                                      input logic [31:0] base = 32'(VEC_BASE_D),
                                      input logic [31:0] num  = 32'(NUM_REGS_D));
    return (addr >= base) && (addr < base + num);
  endfunction

  // Physical entry index for an architectural address (only meaningful when valid).
  function automatic logic [31:0] addr_idx(input logic [31:0] addr,
                                           input logic [31:0] base = 32'(VEC_BASE_D));
    return addr - base;
  endfunction

endpackage

// File: rtl/vreg_clear_seq.sv
// Bulk-clear sequencer: walks a counter over every physical entry, one per
// cycle, and reports busy while doing so. Requests arriving mid-sequence are
// ignored so a clear always runs to completion exactly once.
module vreg_clear_seq
  import vreg_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_D,
  parameter int CNT_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_start,
  output logic             busy,
  output logic             clr_en,
  output logic [CNT_W-1:0] clr_idx
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_REGS - 1);

  vr_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // State and counter registers; reset wins over any sequence in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= VR_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: the counter stops at the last entry instead of wrapping.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      VR_IDLE: begin
        if (clr_start) begin
          state_d = VR_CLEAR;
          cnt_d   = '0;
        end
      end
      VR_CLEAR: begin
        if (cnt_q == LAST) begin
          state_d = VR_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = VR_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs: busy spans exactly the NUM_REGS cycles spent in CLEAR.
  always_comb begin
    busy    = (state_q == VR_CLEAR);
    clr_en  = (state_q == VR_CLEAR);
    clr_idx = cnt_q;
  end

endmodule

// File: rtl/vreg_file_masked.sv
// Parametrised vector register file with per-lane write masking, a bulk
// clear engine (vreg_clear_seq) and a dropped-write pulse.
// Optional macro VREG_BYPASS_EN: forwards the in-flight masked write to a
// same-cycle read of the same address; without it reads see stored data only.
module vreg_file_masked
  import vreg_pkg::*;
#(
  parameter int LANES    = LANES_D,
  parameter int LANE_W   = LANE_W_D,
  parameter int NUM_REGS = NUM_REGS_D,
  parameter int ADDR_W   = 5,
  parameter int VEC_BASE = VEC_BASE_D,
  localparam int DATA_W  = LANES * LANE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [LANES-1:0]  lane_mask,
  input  logic [ADDR_W-1:0] rd,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  input  logic              clr_start,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  output logic              busy,
  output logic              wr_drop
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic [NUM_REGS-1:0][DATA_W-1:0] mem_q;
  logic                            wr_drop_q, wr_drop_d;
  logic                            clr_en;
  logic [IDX_W-1:0]                clr_idx;
  logic                            seq_busy;

  logic             rd_ok, rs1_ok, rs2_ok, wr_fire;
  logic [IDX_W-1:0] wr_idx, rs1_idx, rs2_idx;

  vreg_clear_seq #(
    .NUM_REGS (NUM_REGS),
    .CNT_W    (IDX_W)
  ) u_clr (
    .clk       (clk),
    .rst       (rst),
    .clr_start (clr_start),
    .busy      (seq_busy),
    .clr_en    (clr_en),
    .clr_idx   (clr_idx)
  );

  // Address decode for the write and both read ports.
  always_comb begin
    rd_ok   = addr_valid(32'(rd),  32'(VEC_BASE), 32'(NUM_REGS));
    rs1_ok  = addr_valid(32'(rs1), 32'(VEC_BASE), 32'(NUM_REGS));
    rs2_ok  = addr_valid(32'(rs2), 32'(VEC_BASE), 32'(NUM_REGS));
    wr_idx  = IDX_W'(addr_idx(32'(rd),  32'(VEC_BASE)));
    rs1_idx = IDX_W'(addr_idx(32'(rs1), 32'(VEC_BASE)));
    rs2_idx = IDX_W'(addr_idx(32'(rs2), 32'(VEC_BASE)));
    // A write lands only from IDLE; anything else with we=1 is dropped.
    wr_fire   = we & rd_ok & ~seq_busy;
    wr_drop_d = we & (~rd_ok | seq_busy);
  end

  // Storage: clear walk and masked write are mutually exclusive because
  // writes are refused while the sequencer is busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '0;
    end else if (clr_en) begin
      mem_q[clr_idx] <= '0;
    end else if (wr_fire) begin
      for (int l = 0; l < LANES; l++) begin
        if (lane_mask[l]) mem_q[wr_idx][l*LANE_W +: LANE_W] <= wdata[l*LANE_W +: LANE_W];
      end
    end
  end

  // Dropped-write pulse, visible the cycle after the offending edge.
  always_ff @(posedge clk) begin
    if (rst) wr_drop_q <= 1'b0;
    else     wr_drop_q <= wr_drop_d;
  end

  // Read port 1: stored entry, optionally overlaid with the in-flight write.
  always_comb begin
    rdata1 = rs1_ok ? mem_q[rs1_idx] : '0;
`ifdef VREG_BYPASS_EN
    if (wr_fire && (rs1 == rd)) begin
      for (int l = 0; l < LANES; l++) begin
        if (lane_mask[l]) rdata1[l*LANE_W +: LANE_W] = wdata[l*LANE_W +: LANE_W];
      end
    end
`endif
  end

  // Read port 2: same structure as port 1.
  always_comb begin
    rdata2 = rs2_ok ? mem_q[rs2_idx] : '0;
`ifdef VREG_BYPASS_EN
    if (wr_fire && (rs2 == rd)) begin
      for (int l = 0; l < LANES; l++) begin
        if (lane_mask[l]) rdata2[l*LANE_W +: LANE_W] = wdata[l*LANE_W +: LANE_W];
      end
    end
`endif
  end

  assign busy    = seq_busy;
  assign wr_drop = wr_drop_q;

endmodule

// File: tb/tb_vreg_file_masked.sv
// Bench for vreg_file_masked: directed vector table, clear/reset sequences
// and a randomized run, all against a queue-based reference model.
module tb_vreg_file_masked;

  localparam logic [255:0] ONES = {256{1'b1}};
  localparam logic [255:0] Z    = 256'd0;
  localparam logic [255:0] P100 = 256'd100;
  localparam logic [255:0] AA   = 256'hAAAA_AAAA;
  localparam logic [255:0] A5P  = {32'h0, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF,
                                   32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF, 32'h0};
  localparam logic [255:0] M0F  = {{4{32'hFFFF_FFFF}}, {4{32'h0}}};
`ifdef VREG_BYPASS_EN
  localparam logic [255:0] BYP = M0F;
`else
  localparam logic [255:0] BYP = ONES;
`endif

  logic         clk = 1'b0;
  logic         rst, we, clr_start;
  logic [7:0]   lane_mask;
  logic [4:0]   rd, rs1, rs2;
  logic [255:0] wdata, rdata1, rdata2;
  logic         busy, wr_drop;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  bit model_en = 0;

  // Reference model: plain array of entries plus a queue of entries still to clear.
  logic [255:0] m_mem [16];
  int           m_clrq[$];
  bit           m_drop;

  typedef struct {
    logic rst, we, clr;
    logic [7:0] mask;
    logic [4:0] rd, rs1, rs2;
    logic [255:0] wdata;
    bit chk;
    logic [255:0] e1, e2;
    logic eb, ed;
  } vec_t;

  vreg_file_masked dut (
    .clk(clk), .rst(rst), .we(we), .lane_mask(lane_mask), .rd(rd), .wdata(wdata),
    .rs1(rs1), .rs2(rs2), .clr_start(clr_start), .rdata1(rdata1), .rdata2(rdata2),
    .busy(busy), .wr_drop(wr_drop)
  );

  always #5 clk = ~clk;

  function automatic bit vld(input logic [4:0] a);
    return a >= 5'd16;
  endfunction

  function automatic logic [255:0] merge(input logic [255:0] old, input logic [255:0] wd,
                                         input logic [7:0] m);
    logic [255:0] v;
    v = old;
    for (int l = 0; l < 8; l++) if (m[l]) v[l*32 +: 32] = wd[l*32 +: 32];
    return v;
  endfunction

  function automatic logic [255:0] exp_read(input logic [4:0] a);
    logic [255:0] v;
    v = '0;
    if (vld(a)) v = m_mem[int'(a) - 16];
`ifdef VREG_BYPASS_EN
    if (we && vld(rd) && m_clrq.size() == 0 && a == rd) v = merge(v, wdata, lane_mask);
`endif
    return v;
  endfunction

  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, got, exp);
    end
  endtask

  task automatic model_step();
    bit b;
    int i;
    if (rst) begin
      foreach (m_mem[k]) m_mem[k] = '0;
      m_clrq.delete();
      m_drop = 0;
    end else begin
      b = (m_clrq.size() != 0);
      m_drop = we && (!vld(rd) || b);
      if (b) begin
        i = m_clrq.pop_front();
        m_mem[i] = '0;
      end else begin
        if (we && vld(rd)) m_mem[int'(rd) - 16] = merge(m_mem[int'(rd) - 16], wdata, lane_mask);
        if (clr_start) for (int k = 0; k < 16; k++) m_clrq.push_back(k);
      end
    end
  endtask

  // One clock: sample mid-cycle, compare with the model, then advance both.
  task automatic cycle(output logic sb, output logic sd, output logic [255:0] s1, output logic [255:0] s2);
    #3;
    sb = busy; sd = wr_drop; s1 = rdata1; s2 = rdata2;
    if (model_en) begin
      chk("m_rdata1", rdata1, exp_read(rs1));
      chk("m_rdata2", rdata2, exp_read(rs2));
      chk("m_busy", 256'(busy), 256'(m_clrq.size() != 0));
      chk("m_wr_drop", 256'(wr_drop), 256'(m_drop));
    end
    @(posedge clk);
    model_step();
    model_en = 1;
    cyc++;
    #1;
  endtask

  task automatic drive(input logic r, input logic w, input logic c, input logic [7:0] m,
                       input logic [4:0] a, input logic [255:0] d, input logic [4:0] r1,
                       input logic [4:0] r2);
    rst = r; we = w; clr_start = c; lane_mask = m; rd = a; wdata = d; rs1 = r1; rs2 = r2;
  endtask

  function automatic vec_t mkv(input logic r, input logic w, input logic c, input logic [7:0] m,
                               input logic [4:0] a, input logic [255:0] d, input logic [4:0] r1,
                               input logic [4:0] r2, input bit ck, input logic [255:0] e1,
                               input logic [255:0] e2, input logic eb, input logic ed);
    vec_t v;
    v.rst = r; v.we = w; v.clr = c; v.mask = m; v.rd = a; v.wdata = d; v.rs1 = r1; v.rs2 = r2;
    v.chk = ck; v.e1 = e1; v.e2 = e2; v.eb = eb; v.ed = ed;
    return v;
  endfunction

  vec_t tbl[$];
  logic sb, sd;
  logic [255:0] s1, s2;
  int busy_cnt;

  initial begin
    // rst, we, clr, mask, rd, wdata, rs1, rs2, chk, e_rdata1, e_rdata2, e_busy, e_drop
    tbl.push_back(mkv(1, 0, 0, 8'h00,  0, Z,    16, 31, 0, Z,    Z,    0, 0));
    tbl.push_back(mkv(0, 0, 0, 8'h00,  0, Z,    16, 31, 1, Z,    Z,    0, 0));
    tbl.push_back(mkv(0, 1, 0, 8'hFF, 16, P100, 20, 31, 1, Z,    Z,    0, 0));
    tbl.push_back(mkv(0, 1, 0, 8'h01, 18, AA,   16, 31, 1, P100, Z,    0, 0));
    tbl.push_back(mkv(0, 1, 0, 8'hFF, 17, ONES, 18, 16, 1, AA,   P100, 0, 0));
    tbl.push_back(mkv(0, 1, 0, 8'hA5, 17, Z,    18, 16, 1, AA,   P100, 0, 0));
    tbl.push_back(mkv(0, 1, 0, 8'hFF,  3, ONES, 17, 16, 1, A5P,  P100, 0, 0));
    tbl.push_back(mkv(0, 0, 0, 8'h00,  0, Z,    17, 18, 1, A5P,  AA,   0, 1));
    tbl.push_back(mkv(0, 0, 0, 8'hFF, 16, ONES, 16, 20, 1, P100, Z,    0, 0));
    tbl.push_back(mkv(0, 1, 0, 8'hFF, 19, ONES, 16, 16, 1, P100, P100, 0, 0));
    tbl.push_back(mkv(0, 1, 0, 8'h0F, 19, Z,    19, 31, 1, BYP,  Z,    0, 0));
    tbl.push_back(mkv(0, 1, 0, 8'h00, 19, ONES, 19, 17, 1, M0F,  A5P,  0, 0));
    tbl.push_back(mkv(0, 1, 0, 8'hFF, 15, ONES, 19,  0, 1, M0F,  Z,    0, 0));
    tbl.push_back(mkv(0, 1, 0, 8'hFF, 31, ONES, 30, 16, 1, Z,    P100, 0, 1));
    tbl.push_back(mkv(0, 0, 0, 8'h00,  0, Z,    31, 16, 1, ONES, P100, 0, 0));

    foreach (m_mem[k]) m_mem[k] = '0;
    m_drop = 0;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].we, tbl[i].clr, tbl[i].mask, tbl[i].rd, tbl[i].wdata,
            tbl[i].rs1, tbl[i].rs2);
      cycle(sb, sd, s1, s2);
      if (tbl[i].chk) begin
        chk($sformatf("tbl%0d_rdata1", i), s1, tbl[i].e1);
        chk($sformatf("tbl%0d_rdata2", i), s2, tbl[i].e2);
        chk($sformatf("tbl%0d_busy", i), 256'(sb), 256'(tbl[i].eb));
        chk($sformatf("tbl%0d_wr_drop", i), 256'(sd), 256'(tbl[i].ed));
      end
    end

    // Bulk clear: preload every entry, then watch the walk.
    for (int i = 0; i < 16; i++) begin
      drive(0, 1, 0, 8'hFF, 5'(16 + i), {8{32'h1000_0000 + 32'(i)}}, 16, 31);
      cycle(sb, sd, s1, s2);
    end
    drive(0, 0, 1, 8'h00, 0, Z, 16, 31);
    cycle(sb, sd, s1, s2);
    chk("clr_busy_pre", 256'(sb), 256'd0);
    busy_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      drive(0, (k == 2), (k == 8), 8'hFF, 20, ONES, 16, 31);
      cycle(sb, sd, s1, s2);
      if (sb) busy_cnt++;
      if (k == 0)  chk("clr_e0_hold", s1, {8{32'h1000_0000}});
      if (k == 1)  chk("clr_e0_zero", s1, Z);
      if (k == 3)  chk("clr_drop_busy", 256'(sd), 256'd1);
      if (k == 4)  chk("clr_drop_pulse", 256'(sd), 256'd0);
      if (k == 15) chk("clr_e15_hold", s2, {8{32'h1000_000F}});
      if (k == 15) chk("clr_busy_last", 256'(sb), 256'd1);
      if (k == 16) chk("clr_e15_zero", s2, Z);
      if (k == 16) chk("clr_busy_fall", 256'(sb), 256'd0);
    end
    chk("clr_busy_cycles", 256'(busy_cnt), 256'd16);
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 0, 8'h00, 0, Z, 5'(16 + 2*i), 5'(17 + 2*i));
      cycle(sb, sd, s1, s2);
      chk($sformatf("clr_all_%0d", 2*i), s1, Z);
      chk($sformatf("clr_all_%0d", 2*i + 1), s2, Z);
    end

    // Reset in the middle of a clear, together with a write.
    for (int i = 0; i < 16; i++) begin
      drive(0, 1, 0, 8'hFF, 5'(16 + i), ONES, 16, 31);
      cycle(sb, sd, s1, s2);
    end
    drive(0, 0, 1, 8'h00, 0, Z, 16, 31);
    cycle(sb, sd, s1, s2);
    for (int k = 0; k < 5; k++) begin
      drive(0, 0, 0, 8'h00, 0, Z, 16, 31);
      cycle(sb, sd, s1, s2);
    end
    chk("rst_mid_busy_before", 256'(sb), 256'd1);
    drive(1, 1, 0, 8'hFF, 30, ONES, 16, 31);
    cycle(sb, sd, s1, s2);
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 0, 8'h00, 0, Z, 5'(16 + 2*i), 5'(17 + 2*i));
      cycle(sb, sd, s1, s2);
      if (i == 0) chk("rst_mid_busy", 256'(sb), 256'd0);
      chk($sformatf("rst_all_%0d", 2*i), s1, Z);
      chk($sformatf("rst_all_%0d", 2*i + 1), s2, Z);
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      logic [255:0] d;
      logic [4:0] a;
      for (int l = 0; l < 8; l++) d[l*32 +: 32] = $urandom;
      a = 5'($urandom_range(0, 31));
      drive(($urandom_range(0, 99) == 0), $urandom_range(0, 1) == 1,
            ($urandom_range(0, 29) == 0),
            ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom),
            a, d,
            ($urandom_range(0, 1) == 1) ? a : 5'($urandom_range(0, 31)),
            5'($urandom_range(0, 31)));
      cycle(sb, sd, s1, s2);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
